// File: rtl/display_link_pkg.sv
// Shared constants and types for the display link transmit framer.
// Clock-lane pulse codes, sideband bit layout and command word format.
package display_link_pkg;

    localparam int CMD_W = 12;
    localparam int SB_W  = 15;

    localparam int SB_CMD_LSB = 0;
    localparam int SB_PRESENT = 12;
    localparam int SB_SCL     = 13;
    localparam int SB_SDA     = 14;

    localparam logic [11:0] CODE_BASE = 12'h00F;
    localparam logic [11:0] CODE_SYNC = 12'hFFF;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } cmd_t;

    // Pulse of (4 + code) ones starting at the LSB.
    function automatic logic [11:0] clk_code(input logic [2:0] code);
        return (CODE_BASE << code) | ~(12'hFFF << code);
    endfunction

endpackage

// File: rtl/display_cmd_fifo.sv
// Synchronous command FIFO, read data shown combinationally at the head.
// Latency: full/empty change the clock after push/pop; push when full is ignored unless popped the same clock.
module display_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         c,
    input  logic         r_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge c) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/display_link_tx.sv
// Host-to-display link framer: pixels on data lanes, sideband/flags as clock-lane pulse widths.
// Nibbles appear one clock after slot phase 0; pixel source is paced by pixel_ready, commands dropped (sticky flag) when full.
module display_link_tx
    import display_link_pkg::*;
#(
    parameter int PIXEL_W     = 16,
    parameter int LANES       = 1,
    parameter int SLOTS       = 25,
    parameter int PIXEL_SLOTS = 20,
    parameter int CMD_DEPTH   = 4
) (
    input  logic                 c,
    input  logic                 r_n,
    input  logic                 pixel_valid,
    input  logic [PIXEL_W-1:0]   pixel_data,
    input  logic                 pixel_first,
    output logic                 pixel_ready,
    input  logic                 blank,
    input  logic                 cmd_valid,
    input  logic [3:0]           cmd_addr,
    input  logic [7:0]           cmd_data,
    output logic                 cmd_full,
    output logic                 cmd_overflow,
    input  logic                 sda_t,
    input  logic                 scl_t,
    output logic [4*LANES-1:0]   data_nib,
    output logic [3:0]           clk_nib,
    output logic                 frame_start
);
    localparam int NIB_W     = 4 * LANES;
    localparam int SLOT_CLKS = PIXEL_W / NIB_W;
    localparam int SLOT_BW   = $clog2(SLOTS);
    localparam int PH_BW     = $clog2(SLOT_CLKS);

    logic [1:0]         rst_sync;
    logic               rst_n;

    logic [SLOT_BW-1:0] slot;
    logic [PH_BW-1:0]   phase;
    logic               last_phase;
    logic               last_slot;
    logic               slot_start;
    logic               frame_edge;
    logic               accept;

    logic [PIXEL_W-1:0] dsr;
    logic [11:0]        csr;
    logic [11:0]        clk_load;
    logic [2:0]         code;

    cmd_t               cmd_in;
    logic [CMD_W-1:0]   fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_pop;

    logic [SB_W-1:0]    sb_q;
    logic [SB_W-1:0]    sb_next;
    logic [15:0]        sb_bits;
    logic               sb_bit;

    // Reset asserts immediately, releases two clocks after r_n rises.
    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign last_phase = (phase == PH_BW'(SLOT_CLKS - 1));
    assign last_slot  = (slot == SLOT_BW'(SLOTS - 1));
    assign slot_start = (phase == '0);
    assign frame_edge = slot_start & (slot == '0);
    assign accept     = slot_start & pixel_valid & ~blank & (slot < SLOT_BW'(PIXEL_SLOTS));

    assign cmd_in   = '{addr: cmd_addr, data: cmd_data};
    assign fifo_pop = frame_edge & ~fifo_empty;
    assign cmd_full = fifo_full;

    display_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     (CMD_W)
    ) u_cmd_fifo (
        .c     (c),
        .r_n   (rst_n),
        .push  (cmd_valid),
        .din   (cmd_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        sb_next = '0;
        sb_next[SB_SDA]     = sda_t;
        sb_next[SB_SCL]     = scl_t;
        sb_next[SB_PRESENT] = ~fifo_empty;
        if (!fifo_empty) begin
            sb_next[SB_CMD_LSB +: CMD_W] = fifo_dout;
        end
    end

    // Slot 0 is coded in the same clock the word is latched, so it uses the fresh value.
    assign sb_bits = {1'b0, sb_q};
    always_comb begin
        sb_bit = 1'b0;
        if (slot == '0) begin
            sb_bit = sb_next[0];
        end else if (slot < SLOT_BW'(SB_W)) begin
            sb_bit = sb_bits[slot[3:0]];
        end
    end

    always_comb begin
        code = 3'd0;
        if (sb_bit) begin
            code = 3'd3;
        end
        if (accept) begin
            code = code + (pixel_first ? 3'd2 : 3'd1);
        end
        clk_load = last_slot ? CODE_SYNC : clk_code(code);
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            slot         <= '0;
            phase        <= '0;
            dsr          <= '0;
            csr          <= '0;
            sb_q         <= '0;
            pixel_ready  <= 1'b0;
            frame_start  <= 1'b0;
            cmd_overflow <= 1'b0;
        end else begin
            if (last_phase) begin
                phase <= '0;
                slot  <= last_slot ? '0 : slot + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end

            if (accept) begin
                dsr <= pixel_data;
            end else begin
                dsr <= dsr >> NIB_W;
            end

            if (slot_start) begin
                csr <= clk_load;
            end else begin
                csr <= csr >> 4;
            end

            if (frame_edge) begin
                sb_q <= sb_next;
            end

            if (cmd_valid & fifo_full & ~fifo_pop) begin
                cmd_overflow <= 1'b1;
            end

            pixel_ready <= accept;
            frame_start <= frame_edge;
        end
    end

    assign data_nib = dsr[NIB_W-1:0];
    assign clk_nib  = csr[3:0];

endmodule

// File: tb/tb_display_link_tx.sv
// Self-checking bench for display_link_tx: single-lane and dual-lane instances side by side.
module tb_display_link_tx;
    localparam int SLOTS = 25;
    localparam int SC    = 4;

    logic        c = 1'b0;
    logic        r_n = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        pixel_first = 1'b0;
    logic        blank = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        sda_t = 1'b0;
    logic        scl_t = 1'b0;
    logic [15:0] pixel_data = 16'h0;
    logic [31:0] pixel_data2 = 32'h8765_4321;
    logic [3:0]  cmd_addr = 4'h0;
    logic [7:0]  cmd_data = 8'h0;

    logic        pixel_ready, cmd_full, cmd_overflow, frame_start;
    logic [3:0]  data_nib, clk_nib;
    logic        pixel_ready2, cmd_full2, cmd_overflow2, frame_start2;
    logic [7:0]  data_nib2;
    logic [3:0]  clk_nib2;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] d;
        logic [3:0] ck;
        logic       pr;
        logic       fs;
    } exp_t;
    exp_t sbq[$];

    display_link_tx dut (
        .c(c), .r_n(r_n), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .pixel_first(pixel_first), .pixel_ready(pixel_ready), .blank(blank),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_full(cmd_full), .cmd_overflow(cmd_overflow), .sda_t(sda_t), .scl_t(scl_t),
        .data_nib(data_nib), .clk_nib(clk_nib), .frame_start(frame_start)
    );

    display_link_tx #(.PIXEL_W(32), .LANES(2)) dut2 (
        .c(c), .r_n(r_n), .pixel_valid(pixel_valid), .pixel_data(pixel_data2),
        .pixel_first(pixel_first), .pixel_ready(pixel_ready2), .blank(blank),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_full(cmd_full2), .cmd_overflow(cmd_overflow2), .sda_t(sda_t), .scl_t(scl_t),
        .data_nib(data_nib2), .clk_nib(clk_nib2), .frame_start(frame_start2)
    );

    always #5 c = ~c;

    // Expected output stream for one frame, starting at the frame_start clock.
    task automatic gen_frame(input logic pv, input logic blk, input logic pf,
                             input logic [31:0] pix, input int nw, input logic [14:0] sb);
        exp_t e;
        for (int s = 0; s < SLOTS; s++) begin
            logic        acc;
            logic        b;
            int          code;
            logic [15:0] cv;
            acc  = pv && !blk && (s < 20);
            b    = (s < 15) ? sb[s] : 1'b0;
            code = (b ? 3 : 0) + (acc ? (pf ? 2 : 1) : 0);
            cv   = (s == SLOTS - 1) ? 16'h0FFF : 16'((1 << (4 + code)) - 1);
            for (int p = 0; p < SC; p++) begin
                e.d  = acc ? 8'((pix >> (nw * p)) & ((1 << nw) - 1)) : 8'h00;
                e.ck = cv[4*p +: 4];
                e.pr = acc && (p == 0);
                e.fs = (s == 0) && (p == 0);
                sbq.push_back(e);
            end
        end
    endtask

    task automatic wait_fs(input bit two, input string tag);
        int n;
        n = 0;
        @(posedge c);
        @(negedge c);
        while (((two ? frame_start2 : frame_start) !== 1'b1) && (n < 300)) begin
            @(negedge c);
            n++;
        end
        total++;
        if (n >= 300) $display("FAIL %s: frame_start not seen within 300 clocks", tag);
        else passed++;
    endtask

    // Drains the scoreboard one clock per entry; called at the frame_start negedge.
    task automatic check_q(input bit two, input string tag, output int npr);
        int   idx;
        exp_t e;
        logic [13:0] got, want;
        idx = 0;
        npr = 0;
        while (sbq.size() > 0) begin
            if (idx > 0) @(negedge c);
            e    = sbq.pop_front();
            got  = two ? {data_nib2, clk_nib2, pixel_ready2, frame_start2}
                       : {4'h0, data_nib, clk_nib, pixel_ready, frame_start};
            want = {e.d, e.ck, e.pr, e.fs};
            if (got[1]) npr++;
            total++;
            if (got !== want)
                $display("FAIL %s clk %0d: got d=%h ck=%h pr=%b fs=%b, want d=%h ck=%h pr=%b fs=%b",
                         tag, idx, got[13:6], got[5:2], got[1], got[0],
                         want[13:6], want[5:2], want[1], want[0]);
            else passed++;
            idx++;
        end
    endtask

    task automatic check_idle(input string tag);
        total++;
        if ({data_nib, clk_nib, pixel_ready, frame_start, cmd_full, cmd_overflow} !== 12'h0)
            $display("FAIL %s: outputs d=%h ck=%h pr=%b fs=%b full=%b ovf=%b, want all 0",
                     tag, data_nib, clk_nib, pixel_ready, frame_start, cmd_full, cmd_overflow);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge c);
        @(negedge c);
        check_idle("reset_state");
        total++;
        if ({data_nib2, clk_nib2, pixel_ready2, frame_start2} !== 14'h0)
            $display("FAIL reset_state2: d=%h ck=%h, want 0", data_nib2, clk_nib2);
        else passed++;
        r_n = 1'b1;
    endtask

    task automatic test_pixels();
        int npr;
        pixel_valid = 1'b1;
        pixel_data  = 16'h4321;
        wait_fs(0, "pix_sync");
        gen_frame(1'b1, 1'b0, 1'b0, 32'h4321, 4, 15'h0);
        check_q(0, "pixels", npr);
        total++;
        if (npr !== 20) $display("FAIL pixel_ready_count: got %0d, want 20", npr);
        else passed++;
    endtask

    task automatic test_first();
        int npr;
        pixel_first = 1'b1;
        wait_fs(0, "first_sync");
        gen_frame(1'b1, 1'b0, 1'b1, 32'h4321, 4, 15'h0);
        check_q(0, "first", npr);
        pixel_first = 1'b0;
    endtask

    task automatic test_blank();
        int npr;
        blank = 1'b1;
        wait_fs(0, "blank_sync");
        gen_frame(1'b1, 1'b1, 1'b0, 32'h4321, 4, 15'h0);
        check_q(0, "blank", npr);
        total++;
        if (npr !== 0) $display("FAIL blank_ready_count: got %0d, want 0", npr);
        else passed++;
        blank = 1'b0;
    endtask

    task automatic test_cmd();
        int npr;
        pixel_valid = 1'b0;
        wait_fs(0, "cmd_sync");
        @(posedge c); #1;
        cmd_valid = 1'b1; cmd_addr = 4'h5; cmd_data = 8'hA7;
        @(posedge c); #1;
        cmd_valid = 1'b0;
        wait_fs(0, "cmd_frame");
        gen_frame(1'b0, 1'b0, 1'b0, 32'h0, 4, 15'h15A7);
        gen_frame(1'b0, 1'b0, 1'b0, 32'h0, 4, 15'h0);
        check_q(0, "cmd", npr);
    endtask

    task automatic test_back_to_back();
        int npr;
        logic [11:0] cmds [5];
        pixel_valid = 1'b1;
        sda_t = 1'b1;
        scl_t = 1'b0;
        for (int k = 0; k < 5; k++) cmds[k] = 12'((k + 1) * 256 + k * 17 + 3);
        wait_fs(0, "b2b_sync");
        for (int k = 0; k < 5; k++) begin
            @(posedge c); #1;
            if (k == 3) begin
                total++;
                if (cmd_full !== 1'b0) $display("FAIL full_after_3: got %b, want 0", cmd_full);
                else passed++;
            end
            if (k == 4) begin
                total++;
                if ({cmd_full, cmd_overflow} !== 2'b10)
                    $display("FAIL full_after_4: full=%b ovf=%b, want full=1 ovf=0", cmd_full, cmd_overflow);
                else passed++;
            end
            cmd_valid = 1'b1;
            {cmd_addr, cmd_data} = cmds[k];
        end
        @(posedge c); #1;
        cmd_valid = 1'b0;
        total++;
        if ({cmd_full, cmd_overflow} !== 2'b11)
            $display("FAIL overflow_set: full=%b ovf=%b, want 1 1", cmd_full, cmd_overflow);
        else passed++;
        wait_fs(0, "b2b_frame");
        for (int k = 0; k < 4; k++) gen_frame(1'b1, 1'b0, 1'b0, 32'h4321, 4, {3'b101, cmds[k]});
        gen_frame(1'b1, 1'b0, 1'b0, 32'h4321, 4, 15'h4000);
        check_q(0, "b2b", npr);
        total++;
        if ({cmd_full, cmd_overflow} !== 2'b01)
            $display("FAIL overflow_sticky: full=%b ovf=%b, want 0 1", cmd_full, cmd_overflow);
        else passed++;
        sda_t = 1'b0;
    endtask

    task automatic test_two_lanes();
        int npr;
        pixel_valid = 1'b1;
        wait_fs(1, "lanes_sync");
        gen_frame(1'b1, 1'b0, 1'b0, 32'h8765_4321, 8, 15'h0);
        check_q(1, "two_lanes", npr);
        @(negedge c);
        total++;
        if (frame_start2 !== 1'b1) $display("FAIL two_lanes_period: frame_start=%b after 100 clocks, want 1", frame_start2);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int npr;
        int n;
        pixel_valid = 1'b1;
        pixel_data  = 16'h4321;
        wait_fs(0, "rst_sync");
        repeat (41) @(negedge c);
        total++;
        if (data_nib !== 4'h2) $display("FAIL pre_reset_nib: got %h, want 2", data_nib);
        else passed++;
        r_n = 1'b0;
        #1;
        check_idle("reset_mid");
        repeat (3) @(negedge c);
        r_n = 1'b1;
        n = 0;
        @(negedge c);
        while ((frame_start !== 1'b1) && (n < 10)) begin
            @(negedge c);
            n++;
        end
        total++;
        if (n >= 10) $display("FAIL post_reset_fs: not seen within 10 clocks of release");
        else passed++;
        gen_frame(1'b1, 1'b0, 1'b0, 32'h4321, 4, 15'h0);
        check_q(0, "post_reset", npr);
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_first();
        test_blank();
        test_cmd();
        test_back_to_back();
        test_two_lanes();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
